imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Sequences instruction fetches over a handshaked, variable-latency instruction-memory bus on behalf of the IF stage.
- Accepts a fetch PC and issues exactly one bus request per fetch, with one request outstanding at a time.
- Buffers the returned word until IF/ID captures it, and discards responses to fetches killed by a branch redirect or flush.
- Raises a stall request to the hazard unit while a fetch is pending, and a sticky fault on misalignment, timeout or protocol error.

Parameters:
- TIMEOUT_CYCLES, 256: cycles spent in REQ/WAIT/DRAIN before a fetch is abandoned as a fault (must be >= 2).
- NOP_INSTR, 32'h0000_0013: value driven on fetch_instr after reset.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  IF requests the instruction at fetch_pc (IF not stalled).
- fetch_pc  in  32  byte address to fetch.
- redirect  in  1  branch taken or flush; kills the current fetch.
- fetch_ack  in  1  IF/ID captured the word presented this cycle.
- fetch_valid  out  1  fetch_instr/fetch_pc_out valid (HOLD state).
- fetch_instr  out  32  fetched instruction word.
- fetch_pc_out  out  32  byte address of fetch_instr.
- fetch_busy  out  1  stall request to hazard unit; combinational, = fetch_req && state!=HOLD.
- fetch_fault  out  1  sticky error flag.
- mem_req_valid  out  1  bus request valid; registered, equals (state==REQ).
- mem_req_addr  out  32  byte address of request; registered.
- mem_req_ready  in  1  bus accepts request.
- mem_resp_valid  in  1  response word valid.
- mem_resp_data  in  32  response word.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Internal registers: kill flag, 32-bit timeout counter.
- Reset (asynchronous, any state):
  - state=IDLE, kill=0, counter=0.
  - mem_req_valid=0, mem_req_addr=0.
  - fetch_valid=0, fetch_instr=NOP_INSTR, fetch_pc_out=0.
  - fetch_fault=0.
  - Any in-flight bus transaction is forgotten.
- IDLE:
  - fetch_req && !redirect && fetch_pc[1:0]==0: mem_req_addr<=fetch_pc, go REQ. The request appears on the bus the cycle after fetch_req.
  - fetch_req && fetch_pc[1:0]!=0: set fetch_fault, stay IDLE, no request issued.
- REQ:
  - mem_req_valid=1; mem_req_addr is held stable until mem_req_ready. A request is never withdrawn.
  - redirect && !mem_req_ready: kill<=1, stay in REQ.
  - mem_req_ready: go DRAIN if (kill || redirect), else go WAIT. kill<=0 on exit.
- WAIT:
  - mem_resp_valid && !redirect: fetch_instr<=mem_resp_data, fetch_pc_out<=mem_req_addr, go HOLD.
  - mem_resp_valid && redirect: discard the word, go IDLE.
  - redirect && !mem_resp_valid: go DRAIN.
- DRAIN:
  - mem_resp_valid: discard the word, go IDLE.
  - redirect is ignored.
- HOLD:
  - fetch_valid=1.
  - fetch_ack || redirect: go IDLE; fetch_instr and fetch_pc_out keep their last values.
  - Back-to-back fetch always passes through IDLE. Best-case throughput is one instruction per 4 cycles with a zero-wait bus (IDLE, REQ, WAIT, HOLD).
- Response rules:
  - The earliest legal response is the cycle after the request handshake.
  - mem_resp_valid in IDLE, REQ or HOLD is a protocol error: set fetch_fault, ignore the data, state unchanged.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT/DRAIN.
  - On reaching TIMEOUT_CYCLES: set fetch_fault, force mem_req_valid=0, go IDLE.
  - A late response after a timeout is treated as a protocol error.
- fetch_fault is sticky until reset. It does not block further fetches.
- Simultaneous events:
  - redirect has priority over fetch_ack in HOLD.
  - redirect has priority over fetch_req in IDLE; no request is issued that cycle.

Test Plan:
- Basic fetch, zero-wait bus: fetch_req=1, fetch_pc=0x100, ready and resp after 1 cycle with data 0x00500093 -> mem_req_valid in cycle 1 with addr 0x100. fetch_valid=1 in cycle 3 with instr 0x00500093, pc_out 0x100. fetch_busy=1 in cycles 0-2. fetch_ack -> IDLE.
- Backpressure: ready held low 5 cycles -> mem_req_valid=1 and mem_req_addr=0x100 stable all 5 cycles. Response accepted afterwards. No fault.
- Redirect in REQ with ready low, then ready -> state goes DRAIN. Next response (0xDEADBEEF) is discarded and fetch_valid stays 0. Next fetch at 0x200 returns its own data correctly.
- Redirect in the same cycle as mem_resp_valid in WAIT -> word discarded, IDLE next cycle, fetch_valid never asserts.
- Error cases:
  - fetch_pc=0x102 -> fetch_fault=1, mem_req_valid stays 0.
  - Separately, no response for 256 cycles -> fetch_fault=1, back to IDLE, mem_req_valid=0.
  - Separately, mem_resp_valid while IDLE -> fetch_fault=1.
- Reset asserted mid-WAIT -> all outputs return to reset values immediately (asynchronous). After release, a new fetch at 0x0 completes normally.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl_if
//  Description : Handshaked, variable-latency instruction-memory bus.
//                One request channel (valid/ready with a byte address) and
//                one response channel (valid-only, 32-bit data word).
//  Ports       : master - fetch controller side (drives the request)
//                slave  - memory side (accepts requests, returns words)
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction fetch sequencer for the IF stage. Issues one
//                bus request per fetch (one outstanding at a time), buffers
//                the returned word until IF/ID acknowledges it, discards
//                responses belonging to fetches killed by a redirect, and
//                flags misalignment, timeout and protocol errors through a
//                sticky fault bit.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                fetch_req/fetch_pc    - fetch request from IF
//                redirect              - branch/flush, kills current fetch
//                fetch_ack             - IF/ID captured the presented word
//                fetch_valid/instr/pc_out - word presented to IF/ID
//                fetch_busy            - stall request to hazard unit
//                fetch_fault           - sticky error flag
//                mem                   - instruction-memory bus (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req,
    input  logic [31:0]               fetch_pc,
    input  logic                      redirect,
    input  logic                      fetch_ack,
    output logic                      fetch_valid,
    output logic [31:0]               fetch_instr,
    output logic [31:0]               fetch_pc_out,
    output logic                      fetch_busy,
    output logic                      fetch_fault,
    imem_fetch_ctrl_if.master         mem
);

    // Counter value on the last cycle a fetch may spend in REQ/WAIT/DRAIN.
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_kill;
    logic [31:0] r_count;
    logic        r_mem_req_valid;
    logic [31:0] r_mem_req_addr;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc_out;
    logic        r_fetch_fault;

    logic        w_busy_state;
    logic        w_timeout;
    logic        w_proto_err;
    logic        w_misalign;

    // The timeout only counts while a bus transaction is in progress.
    assign w_busy_state = (r_state == S_REQ) || (r_state == S_WAIT) ||
                          (r_state == S_DRAIN);
    assign w_timeout    = w_busy_state && (r_count == c_TIMEOUT_LAST);

    // A response is only legal once a request has been handshaked and not
    // yet answered (WAIT/DRAIN). Anywhere else it is dropped and flagged;
    // the remaining inputs of that cycle are still processed normally.
    assign w_proto_err  = mem.mem_resp_valid &&
                          ((r_state == S_IDLE) || (r_state == S_REQ) ||
                           (r_state == S_HOLD));

    // Redirect kills the fetch before it starts, so no fault either.
    assign w_misalign   = (r_state == S_IDLE) && fetch_req && !redirect &&
                          (fetch_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_kill          <= 1'b0;
            r_count         <= 32'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= 32'd0;
            r_fetch_valid   <= 1'b0;
            r_fetch_instr   <= NOP_INSTR;
            r_fetch_pc_out  <= 32'd0;
            r_fetch_fault   <= 1'b0;
        end else begin
            // Sticky: only reset clears it, and it never blocks fetching.
            if (w_proto_err || w_misalign || w_timeout) begin
                r_fetch_fault <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (fetch_req && !redirect && (fetch_pc[1:0] == 2'b00)) begin
                        r_mem_req_addr  <= fetch_pc;
                        r_mem_req_valid <= 1'b1;
                        r_count         <= 32'd0;
                        r_kill          <= 1'b0;
                        r_state         <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (w_timeout) begin
                        r_mem_req_valid <= 1'b0;
                        r_kill          <= 1'b0;
                        r_state         <= S_IDLE;
                    end else if (mem.mem_req_ready) begin
                        // Handshake done; a killed fetch still owes us a
                        // response, which DRAIN swallows.
                        r_mem_req_valid <= 1'b0;
                        r_kill          <= 1'b0;
                        r_count         <= r_count + 32'd1;
                        r_state         <= (r_kill || redirect) ? S_DRAIN : S_WAIT;
                    end else begin
                        // The request stays on the bus; remember the kill.
                        if (redirect) begin
                            r_kill <= 1'b1;
                        end
                        r_count <= r_count + 32'd1;
                    end
                end

                S_WAIT: begin
                    if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else if (mem.mem_resp_valid) begin
                        if (redirect) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_fetch_instr  <= mem.mem_resp_data;
                            r_fetch_pc_out <= r_mem_req_addr;
                            r_fetch_valid  <= 1'b1;
                            r_state        <= S_HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            r_state <= S_DRAIN;
                        end
                        r_count <= r_count + 32'd1;
                    end
                end

                S_DRAIN: begin
                    // Redirect is irrelevant here: the word is dropped anyway.
                    if (w_timeout || mem.mem_resp_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end

                S_HOLD: begin
                    // Word and PC stay on the outputs after leaving HOLD.
                    if (fetch_ack || redirect) begin
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_fetch_valid   <= 1'b0;
                    r_kill          <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_busy        = fetch_req && (r_state != S_HOLD);
    assign fetch_valid       = r_fetch_valid;
    assign fetch_instr       = r_fetch_instr;
    assign fetch_pc_out      = r_fetch_pc_out;
    assign fetch_fault       = r_fetch_fault;
    assign mem.mem_req_valid = r_mem_req_valid;
    assign mem.mem_req_addr  = r_mem_req_addr;

endmodule
`default_nettype wire
